can_eo_frame_tx: RTL and testbench
==================================

# can_eo_frame_tx

Transmit side of CAN error/overload frame handling: on request from the protocol controller, drives an error flag (active: 6 dominant; passive: 6 recessive) or an overload flag onto `tx`, then rides out flag superposition from other nodes and the 8-bit recessive delimiter by monitoring `rx`. Sits between the bit-timing unit, which supplies the sample-point strobe, and the CAN transceiver pins. Pulses `done` when the bus is ready for intermission.

## Interface
- `FLAG_LEN`, 6: flag length in bits.
- `DELIM_LEN`, 8: delimiter length in recessive bits.
- `SUPERPOS_MAX`, 6: dominant bits tolerated after own flag before flagging a superposition error.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `bit_tick` in 1: one-cycle sample-point strobe; the FSM advances only on cycles with `bit_tick`=1.
- `rx` in 1: bus level (0 = dominant), valid at `bit_tick`.
- `err_req` in 1: level request for an error frame.
- `ovld_req` in 1: level request for an overload frame.
- `err_passive` in 1: node is error-passive; sampled with the request.
- `tx` out 1: bus drive (1 = recessive).
- `busy` out 1: high from frame start to `done`.
- `kind` out 1: latched frame type (0 = error, 1 = overload).
- `done` out 1: one-cycle pulse when the delimiter is complete.
- `bit_err` out 1: one-cycle pulse when `tx`=0 but `rx`=1 during an active flag.
- `superpos_err` out 1: one-cycle pulse when dominant bits after the flag exceed `SUPERPOS_MAX`.
- `delim_err` out 1: one-cycle pulse when a dominant bit is seen in the delimiter.

## Operation
- States: IDLE, FLAG, WAIT_REC, DELIM. There is one 4-bit counter `cnt`.
- IDLE:
  - `tx`=1.
  - On `bit_tick` with `err_req` or `ovld_req`: latch `kind` (error wins if both are high), latch `passive`, set `cnt`=0, `busy`=1, go to FLAG.
  - Entering FLAG drives `tx`=~passive. Overload frames always drive dominant, so `passive` is ignored for them.
- FLAG:
  - Each tick: if `tx`=0 and `rx`=1, pulse `bit_err`. Continue regardless.
  - At the tick where `cnt`==FLAG_LEN-1: `tx`<=1, `cnt`<=0, go to WAIT_REC. Otherwise `cnt`++.
- WAIT_REC:
  - Tick with `rx`=0: `cnt`++, saturating at 15.
  - Pulse `superpos_err` once, on the tick where `cnt` becomes SUPERPOS_MAX+1. Stay in WAIT_REC.
  - Tick with `rx`=1: this tick is delimiter bit 1. Set `cnt`<=1 and go to DELIM.
- DELIM:
  - Tick with `rx`=0: pulse `delim_err`, set `cnt`<=1, go to WAIT_REC. The dominant bit counts as superposition bit 1.
  - Tick with `rx`=1 and `cnt`==DELIM_LEN-1: pulse `done`, clear `busy`, go to IDLE. Otherwise `cnt`++.
- Requests arriving while `busy` is high are ignored; no queueing. A request still high at the IDLE tick after `done` starts a new frame.
- All error pulses are informational only; the FSM path is unchanged except for the DELIM→WAIT_REC return.

## Timing
- Reset values: `tx`=1, `busy`=0, `kind`=0, `done`=0, all error pulses 0, state IDLE, `cnt`=0.
- Reset mid-frame releases the bus (`tx`=1) on the next clock edge. Nothing is restored.
- All outputs are registered.
  - `tx`, `busy` and `kind` change in the cycle after the qualifying `bit_tick`.
  - Pulses are high for exactly one `clk` cycle, the cycle after the tick.
- Start tick T0 drives the flag for bit periods T1–T6; `tx` returns to 1 after T6.
- With a clean bus, the delimiter is ticks T7–T14 and `done` fires after T14.
- Each extra dominant bit after the flag delays `done` by one bit time.
- `rx` is ignored on cycles without `bit_tick`.

## Structure
- Shared package `can_frame_pkg` holds:
  - the state enum `eo_tx_state_t`;
  - constants `CAN_DOMINANT`=0 and `CAN_RECESSIVE`=1;
  - default flag and delimiter lengths, shared with the receive-side frame tracker.
- Single module. No sub-module is warranted; the counter is inline.

## Test plan
- Active error, clean bus: `err_req` at T0, `rx` mirrors `tx` → `tx`=0 for T1–T6, then 1; `done` after T14; `kind`=0; no error pulses.
- Superposition: as above, but `rx`=0 for T7–T9 → `done` after T17; no `superpos_err`.
- Excess dominant: `rx` held 0 for 7 ticks after the flag → `superpos_err` pulses once on the 7th; `done` after 8 recessive ticks once `rx` rises.
- Passive error with `err_passive`=1 → `tx` stays 1 throughout, no `bit_err`, `done` after T14. An overload request with `err_passive`=1 still drives dominant.
- Delimiter hit: `rx`=0 at T10 → `delim_err` pulse; `done` 8 recessive ticks after `rx` returns to 1.
- Reset at T3 mid-flag → `tx`=1 next cycle, `busy`=0. A simultaneous `err_req` and `ovld_req` afterwards gives `kind`=0, and a further request during the frame is ignored.

Source files
------------

// File: rtl/can_frame_pkg.sv
// Definitions shared by the CAN error/overload frame transmitter and the
// receive-side frame tracker.
package can_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLAG,
    ST_WAIT_REC,
    ST_DELIM
  } eo_tx_state_t;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  localparam int CAN_FLAG_LEN     = 6;
  localparam int CAN_DELIM_LEN    = 8;
  localparam int CAN_SUPERPOS_MAX = 6;

endpackage

// File: rtl/can_eo_frame_tx.sv
// CAN error/overload frame transmitter: drives the flag, then tracks flag
// superposition and the recessive delimiter on rx until the bus is free.
//
// state       | meaning
// ST_IDLE     | bus released, waiting for a request on a bit tick
// ST_FLAG     | driving the 6-bit error/overload flag
// ST_WAIT_REC | flag done, counting dominant bits from other nodes
// ST_DELIM    | counting recessive delimiter bits
module can_eo_frame_tx
  import can_frame_pkg::*;
#(
  parameter int FLAG_LEN     = CAN_FLAG_LEN,
  parameter int DELIM_LEN    = CAN_DELIM_LEN,
  parameter int SUPERPOS_MAX = CAN_SUPERPOS_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_tick,
  input  logic rx,
  input  logic err_req,
  input  logic ovld_req,
  input  logic err_passive,
  output logic tx,
  output logic busy,
  output logic kind,
  output logic done,
  output logic bit_err,
  output logic superpos_err,
  output logic delim_err
);

  localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN - 1);
  localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
  localparam logic [3:0] SUP_LAST   = 4'(SUPERPOS_MAX);

  eo_tx_state_t state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic         passive, passive_n;
  logic         tx_n, busy_n, kind_n;
  logic         done_n, bit_err_n, superpos_err_n, delim_err_n;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    passive_n      = passive;
    kind_n         = kind;
    tx_n           = tx;
    busy_n         = busy;
    done_n         = 1'b0;
    bit_err_n      = 1'b0;
    superpos_err_n = 1'b0;
    delim_err_n    = 1'b0;

    if (bit_tick) begin
      unique case (state)
        ST_IDLE: begin
          tx_n = CAN_RECESSIVE;
          if (err_req || ovld_req) begin
            kind_n    = ~err_req;
            passive_n = err_passive;
            cnt_n     = 4'd0;
            busy_n    = 1'b1;
            state_n   = ST_FLAG;
            // overload flags are always dominant, whatever the error state
            tx_n      = (err_req && err_passive) ? CAN_RECESSIVE : CAN_DOMINANT;
          end
        end

        ST_FLAG: begin
          bit_err_n = (tx == CAN_DOMINANT) && (rx == CAN_RECESSIVE);
          if (cnt == FLAG_LAST) begin
            tx_n    = CAN_RECESSIVE;
            cnt_n   = 4'd0;
            state_n = ST_WAIT_REC;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end

        ST_WAIT_REC: begin
          if (rx == CAN_DOMINANT) begin
            if (cnt != 4'hF) cnt_n = cnt + 4'd1;
            superpos_err_n = (cnt == SUP_LAST);
          end else begin
            cnt_n   = 4'd1;
            state_n = ST_DELIM;
          end
        end

        ST_DELIM: begin
          if (rx == CAN_DOMINANT) begin
            delim_err_n = 1'b1;
            cnt_n       = 4'd1;
            state_n     = ST_WAIT_REC;
          end else if (cnt == DELIM_LAST) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            cnt_n   = 4'd0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      passive      <= 1'b0;
      kind         <= 1'b0;
      tx           <= CAN_RECESSIVE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bit_err      <= 1'b0;
      superpos_err <= 1'b0;
      delim_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      passive      <= passive_n;
      kind         <= kind_n;
      tx           <= tx_n;
      busy         <= busy_n;
      done         <= done_n;
      bit_err      <= bit_err_n;
      superpos_err <= superpos_err_n;
      delim_err    <= delim_err_n;
    end
  end

endmodule

// File: tb/tb_can_eo_frame_tx.sv
// Bench for can_eo_frame_tx: a bit-level model of the frame rules checked on
// every clock, plus per-scenario literal expectations for done timing and pulses.
module tb_can_eo_frame_tx;

  localparam int FLAG_LEN     = 6;
  localparam int DELIM_LEN    = 8;
  localparam int SUPERPOS_MAX = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_tick = 1'b0;
  logic rx = 1'b1;
  logic err_req = 1'b0;
  logic ovld_req = 1'b0;
  logic err_passive = 1'b0;
  logic tx, busy, kind, done, bit_err, superpos_err, delim_err;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  can_eo_frame_tx dut (
    .clk          (clk),
    .reset        (reset),
    .bit_tick     (bit_tick),
    .rx           (rx),
    .err_req      (err_req),
    .ovld_req     (ovld_req),
    .err_passive  (err_passive),
    .tx           (tx),
    .busy         (busy),
    .kind         (kind),
    .done         (done),
    .bit_err      (bit_err),
    .superpos_err (superpos_err),
    .delim_err    (delim_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Frame model: phase 0 = bus free, 1 = sending flag, 2 = after own flag.
  logic m_tx = 1'b1, m_busy = 1'b0, m_kind = 1'b0;
  logic m_done = 1'b0, m_berr = 1'b0, m_sup = 1'b0, m_derr = 1'b0;
  int   m_phase = 0, m_sent = 0, m_dom = 0, m_rec = 0;

  always @(posedge clk) begin
    m_done = 1'b0; m_berr = 1'b0; m_sup = 1'b0; m_derr = 1'b0;
    if (reset) begin
      m_tx = 1'b1; m_busy = 1'b0; m_kind = 1'b0; m_phase = 0;
    end else if (bit_tick) begin
      if (m_phase == 0) begin
        if (err_req || ovld_req) begin
          m_kind  = !err_req;
          m_tx    = m_kind ? 1'b0 : err_passive;
          m_busy  = 1'b1;
          m_phase = 1;
          m_sent  = 0;
        end
      end else if (m_phase == 1) begin
        m_berr = (m_tx == 1'b0) && (rx == 1'b1);
        m_sent++;
        if (m_sent == FLAG_LEN) begin
          m_tx = 1'b1; m_phase = 2; m_dom = 0; m_rec = 0;
        end
      end else begin
        if (!rx) begin
          if (m_rec > 0) begin
            m_derr = 1'b1; m_dom = 1; m_rec = 0;
          end else begin
            m_dom++;
            m_sup = (m_dom == SUPERPOS_MAX + 1);
          end
        end else begin
          m_rec++;
          if (m_rec == DELIM_LEN) begin
            m_done = 1'b1; m_busy = 1'b0; m_phase = 0;
          end
        end
      end
    end
  end

  int cur_tick = 0, next_tick = 0;
  int obs_done_tick, obs_done_cnt, obs_berr, obs_sup, obs_derr, obs_txlow;

  always @(negedge clk) begin
    if (chk_on) begin
      check("tx", tx, m_tx);
      check("busy", busy, m_busy);
      check("kind", kind, m_kind);
      check("done", done, m_done);
      check("bit_err", bit_err, m_berr);
      check("superpos_err", superpos_err, m_sup);
      check("delim_err", delim_err, m_derr);
      if (done === 1'b1) begin obs_done_tick = cur_tick; obs_done_cnt++; end
      if (bit_err === 1'b1) obs_berr++;
      if (superpos_err === 1'b1) obs_sup++;
      if (delim_err === 1'b1) obs_derr++;
    end
  end

  // One bit period: a tick cycle then idle cycles with junk on rx.
  // ext=1 means another node drives dominant; frc=1 forces rx recessive.
  task automatic tick(input logic ext, input logic er, input logic ov, input logic frc, input logic rs);
    @(negedge clk); #1;
    cur_tick = next_tick;
    next_tick++;
    err_req = er; ovld_req = ov; reset = rs;
    if (tx === 1'b0) obs_txlow++;
    rx = frc ? 1'b1 : (m_tx & ~ext);
    bit_tick = 1'b1;
    @(negedge clk); #1;
    bit_tick = 1'b0; reset = 1'b0;
    repeat (3) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
    end
  endtask

  task automatic clear_obs();
    next_tick = 0; obs_done_tick = -1; obs_done_cnt = 0;
    obs_berr = 0; obs_sup = 0; obs_derr = 0; obs_txlow = 0;
  endtask

  task automatic run_frame(input string nm, input logic [31:0] er_m, input logic [31:0] ov_m,
                           input logic [31:0] dom_m, input logic [31:0] frc_m, input logic ps,
                           input int n, input int x_done, input int x_txlow, input int x_berr,
                           input int x_sup, input int x_derr, input logic x_kind, input logic x_busy);
    clear_obs();
    err_passive = ps;
    for (int i = 0; i < n; i++) tick(dom_m[i], er_m[i], ov_m[i], frc_m[i], 1'b0);
    err_req = 1'b0; ovld_req = 1'b0;
    check({nm, ".done_tick"}, obs_done_tick, x_done);
    check({nm, ".done_count"}, obs_done_cnt, 1);
    check({nm, ".tx_low_bits"}, obs_txlow, x_txlow);
    check({nm, ".bit_err_count"}, obs_berr, x_berr);
    check({nm, ".superpos_count"}, obs_sup, x_sup);
    check({nm, ".delim_err_count"}, obs_derr, x_derr);
    check({nm, ".kind"}, kind, x_kind);
    check({nm, ".busy_end"}, busy, x_busy);
  endtask

  initial begin
    clear_obs();
    @(posedge clk); #1;
    chk_on = 1'b1;
    check("reset.tx", tx, 1);
    check("reset.busy", busy, 0);
    check("reset.kind", kind, 0);
    check("reset.done", done, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    //        name              err_m      ovld_m     dom_m      frc_m   ps  n  done txl berr sup derr kind busy
    run_frame("active_clean",   32'h1,     32'h0,     32'h0,     32'h0,  0, 16, 14,  6,  0,   0,  0,  0,   0);
    run_frame("superpos",       32'h1,     32'h0,     32'h380,   32'h0,  0, 19, 17,  6,  0,   0,  0,  0,   0);
    run_frame("excess_dom",     32'h1,     32'h0,     32'h3F80,  32'h0,  0, 23, 21,  6,  0,   1,  0,  0,   0);
    run_frame("passive_err",    32'h1,     32'h0,     32'h0,     32'h0,  1, 16, 14,  0,  0,   0,  0,  0,   0);
    run_frame("ovld_passive",   32'h0,     32'h1,     32'h0,     32'h0,  1, 16, 14,  6,  0,   0,  0,  1,   0);
    run_frame("delim_hit",      32'h1,     32'h0,     32'h400,   32'h0,  0, 20, 18,  6,  0,   0,  1,  0,   0);
    run_frame("bit_err",        32'h1,     32'h0,     32'h0,     32'h14, 0, 16, 14,  6,  2,   0,  0,  0,   0);

    clear_obs();
    err_passive = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, i == 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_reset.tx", tx, 1);
    check("mid_reset.busy", busy, 0);

    run_frame("both_req",       32'h101,   32'h9,     32'h0,     32'h0,  0, 16, 14,  6,  0,   0,  0,  0,   0);
    run_frame("req_after_done", 32'h1,     32'h8000,  32'h0,     32'h0,  0, 16, 14,  6,  0,   0,  0,  1,   1);

    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    check("final.busy", busy, 0);
    check("final.tx", tx, 1);
    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
